// File: rtl/coin_sw_sequencer_pkg.sv
// Shared types and width helpers for the coin switch sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package coin_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  // Width of the shared pulse/gap down-counter. The counter only ever holds
  // a load value of N-1, so $clog2 of the larger period is enough.
  function automatic int CNT_W(input int pulse_cycles, input int gap_cycles);
    int m;
    m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Width of the pending-coin count, which must be able to hold 0..depth.
  function automatic int PEND_W(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/coin_sw_sequencer_if.sv
// Coin sequencer signal bundle between the input/credit side and the core.
// Latency: n/a (wires only).
// Backpressure: none; presses are queued and credit_light_n gates issue.
// Ports: coin_req[1:0], coin_clear, credit_light_n (to sequencer);
//        coin_sw, pending, busy, drop (from sequencer).
interface coin_sw_sequencer_if #(
  parameter int QUEUE_DEPTH = 3
);
  import coin_seq_pkg::*;

  localparam int PW = PEND_W(QUEUE_DEPTH);

  logic [1:0]    coin_req;
  logic          coin_clear;
  logic          credit_light_n;
  logic          coin_sw;
  logic [PW-1:0] pending;
  logic          busy;
  logic          drop;

  // Driver side (input logic / testbench).
  modport master (
    output coin_req, coin_clear, credit_light_n,
    input  coin_sw, pending, busy, drop
  );

  // Sequencer side.
  modport slave (
    input  coin_req, coin_clear, credit_light_n,
    output coin_sw, pending, busy, drop
  );

endinterface

// File: rtl/coin_sw_sequencer_edge_detect.sv
// Two-channel rising-edge detector for the coin buttons.
// Latency: rise is combinational from din against the previous-cycle sample.
// Backpressure: none; a held level reports a single rise.
// Ports: clk_sys, reset_n, din[1:0] (levels), rise[1:0] (one-cycle strobes).
module coin_edge_detect (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] din,
  output logic [1:0] rise
);

  logic [1:0] prev_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/coin_sw_sequencer.sv
// Turns coin-button presses into timed COIN_SW pulses, queued behind credit.
// Latency: press -> pending next cycle -> coin_sw rises the cycle after.
// Backpressure: queue saturates at QUEUE_DEPTH; excess presses strobe drop.
// Ports: clk_sys, reset_n (async, active-low), bus (slave modport):
//        coin_req/coin_clear/credit_light_n in, coin_sw/pending/busy/drop out.
module coin_sw_sequencer
  import coin_seq_pkg::*;
#(
  parameter int PULSE_CYCLES = 600000,
  parameter int GAP_CYCLES   = 57272,
  parameter int QUEUE_DEPTH  = 3
) (
  input logic                clk_sys,
  input logic                reset_n,
  coin_sw_sequencer_if.slave bus
);

  localparam int CW = CNT_W(PULSE_CYCLES, GAP_CYCLES);
  localparam int PW = PEND_W(QUEUE_DEPTH);
  localparam int SW = PW + 1;  // room for pending + 2 before saturation

  // ---------------------------------------------------------------- inputs
  logic [1:0] rise;

  coin_edge_detect u_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (bus.coin_req),
    .rise    (rise)
  );

  // Credit lamp synchronizer; resets to 1 so nothing issues until the core
  // has actually reported "no credit".
  logic [1:0] cl_sync_q;
  logic       cl_s;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cl_sync_q <= 2'b11;
    end else begin
      cl_sync_q <= {cl_sync_q[0], bus.credit_light_n};
    end
  end

  assign cl_s = cl_sync_q[1];

  // ------------------------------------------------------------------ FSM
  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          coin_sw_q, coin_sw_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          drop_q, drop_d;
  logic          dec;

  // State register, including the registered FSM outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      coin_sw_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      coin_sw_q <= coin_sw_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic. Credit is only looked at in IDLE, so a pulse that has
  // started always runs its full PULSE + GAP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((pending_q != '0) && cl_s) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
          dec     = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic, registered alongside the state so coin_sw is glitch-free.
  always_comb begin
    coin_sw_d = (state_d == PULSE);
    busy_d    = (state_d != IDLE);
  end

  // --------------------------------------------------------- pending queue
  // dec only fires with pending > 0, so the subtraction cannot underflow.
  logic [SW-1:0] pend_sum;
  logic          pend_over;

  always_comb begin
    pend_sum  = SW'(pending_q) - SW'(dec) + SW'(rise[0]) + SW'(rise[1]);
    pend_over = (pend_sum > SW'(QUEUE_DEPTH));
    if (bus.coin_clear) begin
      pending_d = '0;
      drop_d    = 1'b0;
    end else begin
      pending_d = pend_over ? PW'(QUEUE_DEPTH) : pend_sum[PW-1:0];
      drop_d    = pend_over;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.coin_sw = coin_sw_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_coin_sw_sequencer.sv
// Directed bench for coin_sw_sequencer with short pulse/gap periods.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives the sequencer through its interface.
module tb_coin_sw_sequencer;

  localparam int PULSE_CYCLES = 8;
  localparam int GAP_CYCLES   = 4;
  localparam int QUEUE_DEPTH  = 3;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  coin_sw_sequencer_if #(.QUEUE_DEPTH(QUEUE_DEPTH)) bus ();

  coin_sw_sequencer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .QUEUE_DEPTH  (QUEUE_DEPTH)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Watch coin_sw for n cycles (sampling first, then advancing).
  task automatic observe(input int n, output int hi, output int rises,
                         output int min_low, output int bsy);
    logic prev;
    int   low_run;
    bit   seen_fall;
    hi = 0; rises = 0; min_low = 9999; bsy = 0;
    prev = bus.coin_sw; low_run = 0; seen_fall = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.busy) bsy++;
      if (bus.coin_sw) begin
        hi++;
        if (!prev) begin
          rises++;
          if (seen_fall && low_run < min_low) min_low = low_run;
        end
        low_run = 0;
      end else begin
        if (prev) seen_fall = 1;
        low_run++;
      end
      prev = bus.coin_sw;
      tick();
    end
  endtask

  initial begin
    int hi, rises, min_low, bsy;

    reset_n            = 1'b0;
    bus.coin_req       = 2'b00;
    bus.coin_clear     = 1'b0;
    bus.credit_light_n = 1'b1;
    #2;
    check("rst_coin_sw", bus.coin_sw, 0);
    check("rst_busy",    bus.busy,    0);
    check("rst_pending", bus.pending, 0);
    check("rst_drop",    bus.drop,    0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    // 1. Single press, held long.
    bus.coin_req = 2'b01;
    tick();
    check("s1_pend1",    bus.pending, 1);
    check("s1_sw_lo",    bus.coin_sw, 0);
    tick();
    check("s1_sw_hi",    bus.coin_sw, 1);
    check("s1_pend0",    bus.pending, 0);
    check("s1_busy",     bus.busy,    1);
    observe(30, hi, rises, min_low, bsy);
    check("s1_hi_len",   hi,    8);
    check("s1_rises",    rises, 0);
    check("s1_busy_len", bsy,   12);
    check("s1_pend_end", bus.pending, 0);
    bus.coin_req = 2'b00;
    tick();

    // 2. Simultaneous press on both players.
    bus.coin_req = 2'b11;
    tick();
    check("s2_pend2", bus.pending, 2);
    observe(40, hi, rises, min_low, bsy);
    check("s2_rises",   rises,   2);
    check("s2_hi",      hi,      16);
    check("s2_min_gap", min_low, GAP_CYCLES + 1);
    check("s2_pend0",   bus.pending, 0);
    bus.coin_req = 2'b00;

    // 3. Overflow while credit is held.
    bus.credit_light_n = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      bus.coin_req = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("s3_pend",     bus.pending, (k < 3) ? k + 1 : 3);
      check("s3_drop",     bus.drop,    (k >= 3) ? 1 : 0);
      bus.coin_req = 2'b00;
      tick();
      check("s3_drop_clr", bus.drop,    0);
      check("s3_sw_lo",    bus.coin_sw, 0);
    end
    bus.credit_light_n = 1'b1;
    observe(60, hi, rises, min_low, bsy);
    check("s3_rises", rises, 3);
    check("s3_hi",    hi,    24);
    check("s3_pend0", bus.pending, 0);

    // 4. Credit hold, then release.
    bus.credit_light_n = 1'b0;
    tick(); tick(); tick();
    bus.coin_req = 2'b01;
    tick();
    check("s4_pend1", bus.pending, 1);
    bus.coin_req = 2'b00;
    observe(100, hi, rises, min_low, bsy);
    check("s4_held_hi", hi, 0);
    check("s4_pend_kept", bus.pending, 1);
    bus.credit_light_n = 1'b1;
    tick();
    check("s4_sw_d1", bus.coin_sw, 0);
    tick();
    check("s4_sw_d2", bus.coin_sw, 0);
    tick();
    check("s4_sw_d3", bus.coin_sw, 1);

    // 5a. Credit returns mid-pulse; pulse must still run full length.
    tick();
    tick();
    bus.credit_light_n = 1'b0;
    observe(20, hi, rises, min_low, bsy);
    check("s5a_len",   hi + 2, 8);
    check("s5a_rises", rises,  0);

    // 5b. coin_clear during GAP with two coins queued.
    bus.credit_light_n = 1'b1;
    tick(); tick(); tick();
    bus.coin_req = 2'b01;
    tick();
    check("s5b_pend1", bus.pending, 1);
    tick();
    check("s5b_sw_hi", bus.coin_sw, 1);
    bus.coin_req = 2'b00;
    tick();
    bus.coin_req = 2'b11;
    tick();
    check("s5b_pend2", bus.pending, 2);
    bus.coin_req = 2'b00;
    for (int i = 0; i < 7; i++) tick();
    check("s5b_gap_sw",   bus.coin_sw, 0);
    check("s5b_gap_busy", bus.busy,    1);
    check("s5b_gap_pend", bus.pending, 2);
    bus.coin_clear = 1'b1;
    bus.coin_req   = 2'b01;
    tick();
    bus.coin_clear = 1'b0;
    check("s5b_clr_pend", bus.pending, 0);
    check("s5b_clr_drop", bus.drop,    0);
    check("s5b_busy_a",   bus.busy,    1);
    tick();
    check("s5b_busy_b",   bus.busy,    1);
    tick();
    check("s5b_idle",     bus.busy,    0);
    bus.coin_req = 2'b00;
    observe(30, hi, rises, min_low, bsy);
    check("s5b_no_pulse", rises, 0);
    check("s5b_pend_end", bus.pending, 0);

    // 6. Asynchronous reset in the middle of a pulse.
    bus.coin_req = 2'b01;
    tick();
    check("s6_pend1", bus.pending, 1);
    tick();
    check("s6_sw_hi", bus.coin_sw, 1);
    bus.coin_req = 2'b11;
    tick();
    check("s6_pend_q", bus.pending, 1);
    tick();
    tick();
    check("s6_sw_c4", bus.coin_sw, 1);
    reset_n = 1'b0;
    #1;
    check("s6_rst_sw",   bus.coin_sw, 0);
    check("s6_rst_pend", bus.pending, 0);
    check("s6_rst_busy", bus.busy,    0);
    bus.coin_req = 2'b00;
    tick();
    tick();
    reset_n = 1'b1;
    observe(30, hi, rises, min_low, bsy);
    check("s6_no_pulse", rises, 0);
    check("s6_pend_end", bus.pending, 0);
    check("s6_busy_end", bus.busy,    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_sw_sequencer.md
Name: coin_sw_sequencer

Overview:
- Converts player coin-button presses into correctly timed COIN_SW pulses for the discrete-logic game core.
- Queues coin presses that arrive while a pulse is in flight or while credit remains, so no press is lost and COIN_SW never fires mid-game.
- Sits in the MiST top level between arcade_inputs (fire buttons) and space_race_top.COIN_SW, and reads CREDIT_LIGHT_N back from the core.

Parameters:
- PULSE_CYCLES, 600000: COIN_SW high time in clk_sys cycles (must exceed 10 ms at 57.272 MHz).
- GAP_CYCLES, 57272: minimum low time between successive pulses (1 ms).
- QUEUE_DEPTH, 3: maximum pending coin count; saturates at this value.

Ports:
- clk_sys  in  1  system clock, 57.272 MHz.
- reset_n  in  1  asynchronous active-low reset.
- coin_req  in  2  level coin buttons; bit0 = player 1, bit1 = player 2; synchronous to clk_sys.
- coin_clear  in  1  synchronous flush of the pending queue.
- credit_light_n  in  1  core credit lamp, active-low; 1 = no credit.
- coin_sw  out  1  pulse to core COIN_SW.
- pending  out  $clog2(QUEUE_DEPTH+1)  queued coins not yet issued.
- busy  out  1  FSM not in IDLE.
- drop  out  1  one-cycle strobe when a press is discarded because the queue is full.

Behaviour:
- Reset (asynchronous, active-low): coin_sw=0, busy=0, drop=0, pending=0, FSM=IDLE, edge registers=0, synchronizer=1 (no credit). coin_sw falls combinationally with reset assertion, including mid-pulse.
- Edge detect: a rise on coin_req[i] is coin_req[i]=1 with its previous-cycle value 0. A held button counts once.
- Each rise adds 1 to pending. Two simultaneous rises add 2.
- pending saturates at QUEUE_DEPTH. Any rise that cannot be stored pulses drop for one cycle, the cycle after the edge.
- credit_light_n passes through a 2-flop synchronizer before use. Call the synchronized value cl_s.
- FSM IDLE:
  - If pending>0 and cl_s=1, go to PULSE next cycle.
  - On that same transition, decrement pending, load the counter with PULSE_CYCLES-1, and set coin_sw=1 (registered).
- FSM PULSE:
  - coin_sw=1; the counter decrements each cycle.
  - At count 0, go to GAP, load GAP_CYCLES-1, and set coin_sw=0.
  - coin_sw is high for exactly PULSE_CYCLES cycles.
- FSM GAP:
  - coin_sw=0; the counter decrements each cycle.
  - At count 0, go to IDLE.
  - Minimum spacing between a falling edge and the next rising edge is GAP_CYCLES+1 cycles.
- A pulse in flight always completes even if cl_s goes 0 during it. cl_s is sampled only in IDLE.
- Queued coins wait in IDLE while cl_s=0 and issue once credit is exhausted.
- Same-cycle decrement and increment: pending_next = min(pending - dec + inc, QUEUE_DEPTH). Drop counts only the excess.
- coin_clear:
  - Forces pending to 0 next cycle and overrides any same-cycle increments; no drop is flagged.
  - Does not abort PULSE or GAP.
- busy = (state != IDLE), registered.
- Counter width is $clog2(max(PULSE_CYCLES, GAP_CYCLES)). Counters never wrap below 0.

Decomposition:
- Package coin_seq_pkg holds:
  - the state enum (IDLE, PULSE, GAP), 2 bits;
  - the CNT_W and PEND_W width functions.
- Sub-module coin_edge_detect: 2-bit registered rising-edge detector with asynchronous active-low reset, instantiated once. Everything else lives in coin_sw_sequencer.

Test Plan:
Parameters for all scenarios: PULSE_CYCLES=8, GAP_CYCLES=4, QUEUE_DEPTH=3. Hold credit_light_n=1 unless stated.
1. Single press: coin_req[0] 0→1 at cycle 10, held for 20 cycles → pending=1 at cycle 11; coin_sw high for exactly cycles 12–19; pending=0 from cycle 12; busy high for 12 cycles; no second pulse.
2. Simultaneous press: both bits rise in the same cycle → pending=2. Two 8-cycle pulses with a ≥5-cycle low gap between them, then pending=0.
3. Overflow: 5 rises on alternating bits while credit_light_n=0 → pending saturates at 3, drop strobes twice, coin_sw stays 0. Release credit_light_n=1 → 3 pulses issue.
4. Credit hold: pending=1 with credit_light_n=0 for 100 cycles → coin_sw stays 0. Set it to 1 → coin_sw rises 3 cycles later (2 synchronizer cycles plus IDLE decision).
5. Mid-pulse events:
   - credit_light_n→0 at pulse cycle 3 → the pulse still lasts 8 cycles.
   - coin_clear during GAP with pending=2 → pending=0, GAP completes, no further pulses.
6. Reset mid-pulse: reset_n low at pulse cycle 4 → coin_sw=0 and pending=0 immediately (asynchronous). After release, no pulse occurs without a new press.
